// File: rtl/sdram_phy_pkg.sv
// sdram_phy_pkg
//   Shared definitions for the SDRAM pin-side stage.
//   - Raw {RASn, CASn, WEn} command encodings (CSn is driven low separately).
//   - Power-up sequencer state enum.
//   - A10 precharge-all address constant.
package sdram_phy_pkg;

    // {RASn, CASn, WEn}
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_MRS   = 3'b000;

    localparam logic [12:0] A10_PRECHARGE_ALL = 13'h0400;

    typedef enum logic [3:0] {
        ST_WAIT,
        ST_PRE,
        ST_WAIT_RP,
        ST_REF1,
        ST_WAIT_RFC1,
        ST_REF2,
        ST_WAIT_RFC2,
        ST_MRS,
        ST_WAIT_MRD,
        ST_RUN
    } init_state_e;

endpackage

// File: rtl/sdram_phy_init_seq.sv
// sdram_init_seq
//   SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, two AUTO REFRESH,
//   LOAD MODE, then RUN.  One shared down-counter times every wait.
// Ports
//   clk        in   clock
//   resetn     in   synchronous active-low reset
//   init_cmd   out  {RASn, CASn, WEn} requested by the sequencer
//   init_cke   out  clock enable request (high once out of reset)
//   init_addr  out  address for the sequencer command
//   init_done  out  high while in RUN
module sdram_init_seq
    import sdram_phy_pkg::*;
#(
    parameter int unsigned INIT_WAIT_CYCLES = 10000,
    parameter int unsigned T_RP             = 3,
    parameter int unsigned T_RFC            = 7,
    parameter int unsigned T_MRD            = 2,
    parameter logic [12:0] MODE_REG         = 13'h030
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [2:0]  init_cmd,
    output logic        init_cke,
    output logic [12:0] init_addr,
    output logic        init_done
);

    localparam int unsigned CNT_MAX = (INIT_WAIT_CYCLES > T_RFC) ? INIT_WAIT_CYCLES : T_RFC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // A command state lasts one cycle, so a T_x spacing leaves T_x-1 wait
    // cycles; the wait state leaves on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] LD_WAIT = CNT_W'(INIT_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC - 2);
    localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'(T_MRD - 2);

    init_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_WAIT;
            cnt_q   <= LD_WAIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        case (state_q)
            ST_WAIT:      if (cnt_zero) state_d = ST_PRE;
            ST_PRE:       begin state_d = ST_WAIT_RP;   cnt_d = LD_RP;  end
            ST_WAIT_RP:   if (cnt_zero) state_d = ST_REF1;
            ST_REF1:      begin state_d = ST_WAIT_RFC1; cnt_d = LD_RFC; end
            ST_WAIT_RFC1: if (cnt_zero) state_d = ST_REF2;
            ST_REF2:      begin state_d = ST_WAIT_RFC2; cnt_d = LD_RFC; end
            ST_WAIT_RFC2: if (cnt_zero) state_d = ST_MRS;
            ST_MRS:       begin state_d = ST_WAIT_MRD;  cnt_d = LD_MRD; end
            ST_WAIT_MRD:  if (cnt_zero) state_d = ST_RUN;
            ST_RUN:       state_d = ST_RUN;
            default:      state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        init_cmd  = CMD_NOP;
        init_cke  = 1'b1;
        init_addr = '0;
        init_done = 1'b0;
        case (state_q)
            ST_PRE: begin
                init_cmd  = CMD_PRE;
                init_addr = A10_PRECHARGE_ALL;
            end
            ST_REF1, ST_REF2: init_cmd = CMD_REF;
            ST_MRS: begin
                init_cmd  = CMD_MRS;
                init_addr = MODE_REG;
            end
            ST_RUN:  init_done = 1'b1;
            default: init_cmd  = CMD_NOP;
        endcase
    end

endmodule

// File: rtl/sdram_phy_init.sv
// sdram_phy_init
//   Pin-side stage between the SDRAM controller and an mt48lc16m16a2.
//   Runs the power-up sequence, then registers controller commands onto
//   the pins, drives the split DQ bus and returns read data after
//   CAS_LATENCY+2 cycles from acceptance.
// Ports
//   io_axiClk / io_axiResetn     clock / synchronous active-low reset
//   io_cmd_*                     controller command (ready only in RUN)
//   io_rsp_valid / io_rsp_data   read response, single-cycle pulse
//   io_initDone                  init sequence complete
//   io_busConflict               sticky: WRITE too soon after a READ
//   io_sdram_*                   device pins (all registered)
module sdram_phy_init
    import sdram_phy_pkg::*;
#(
    parameter int unsigned CAS_LATENCY      = 3,
    parameter int unsigned INIT_WAIT_CYCLES = 10000,
    parameter int unsigned T_RP             = 3,
    parameter int unsigned T_RFC            = 7,
    parameter int unsigned T_MRD            = 2,
    parameter logic [12:0] MODE_REG         = 13'h030
) (
    input  logic        io_axiClk,
    input  logic        io_axiResetn,
    input  logic        io_cmd_valid,
    output logic        io_cmd_ready,
    input  logic        io_cmd_rasn,
    input  logic        io_cmd_casn,
    input  logic        io_cmd_wen,
    input  logic [12:0] io_cmd_addr,
    input  logic [1:0]  io_cmd_ba,
    input  logic [1:0]  io_cmd_dqm,
    input  logic [15:0] io_cmd_wdata,
    output logic        io_rsp_valid,
    output logic [15:0] io_rsp_data,
    output logic        io_initDone,
    output logic        io_busConflict,
    output logic [12:0] io_sdram_ADDR,
    output logic [1:0]  io_sdram_BA,
    input  logic [15:0] io_sdram_DQ_read,
    output logic [15:0] io_sdram_DQ_write,
    output logic        io_sdram_DQ_writeEnable,
    output logic [1:0]  io_sdram_DQM,
    output logic        io_sdram_CKE,
    output logic        io_sdram_CSn,
    output logic        io_sdram_RASn,
    output logic        io_sdram_CASn,
    output logic        io_sdram_WEn
);

    logic [2:0]  init_cmd;
    logic        init_cke;
    logic [12:0] init_addr;
    logic        init_done;

    sdram_init_seq #(
        .INIT_WAIT_CYCLES (INIT_WAIT_CYCLES),
        .T_RP             (T_RP),
        .T_RFC            (T_RFC),
        .T_MRD            (T_MRD),
        .MODE_REG         (MODE_REG)
    ) u_init_seq (
        .clk       (io_axiClk),
        .resetn    (io_axiResetn),
        .init_cmd  (init_cmd),
        .init_cke  (init_cke),
        .init_addr (init_addr),
        .init_done (init_done)
    );

    logic [2:0]  user_cmd;
    logic        accept;
    logic        is_read;
    logic        is_write;
    logic [2:0]  cmd_d;
    logic [12:0] addr_d;
    logic [1:0]  ba_d;
    logic [1:0]  dqm_d;

    // Bit i set: a READ was accepted i+1 cycles before the current cycle.
    // The last stage is the response-valid flop itself.
    logic [CAS_LATENCY+1:0] rd_pipe;

    always_comb begin
        user_cmd = {io_cmd_rasn, io_cmd_casn, io_cmd_wen};
        accept   = io_cmd_ready & io_cmd_valid;
        is_read  = accept & (user_cmd == CMD_READ);
        is_write = accept & (user_cmd == CMD_WRITE);
        cmd_d    = CMD_NOP;
        addr_d   = '0;
        ba_d     = '0;
        dqm_d    = '1;
        if (init_done) begin
            dqm_d = '0;
            if (accept) begin
                cmd_d  = user_cmd;
                addr_d = io_cmd_addr;
                ba_d   = io_cmd_ba;
                dqm_d  = io_cmd_dqm;
            end
        end else begin
            cmd_d  = init_cmd;
            addr_d = init_addr;
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (!io_axiResetn) begin
            io_sdram_CKE            <= 1'b0;
            io_sdram_CSn            <= 1'b1;
            io_sdram_RASn           <= 1'b1;
            io_sdram_CASn           <= 1'b1;
            io_sdram_WEn            <= 1'b1;
            io_sdram_ADDR           <= '0;
            io_sdram_BA             <= '0;
            io_sdram_DQM            <= '1;
            io_sdram_DQ_write       <= '0;
            io_sdram_DQ_writeEnable <= 1'b0;
            io_cmd_ready            <= 1'b0;
            io_initDone             <= 1'b0;
            io_rsp_data             <= '0;
            io_busConflict          <= 1'b0;
            rd_pipe                 <= '0;
        end else begin
            io_sdram_CKE                              <= init_cke;
            io_sdram_CSn                              <= 1'b0;
            {io_sdram_RASn, io_sdram_CASn, io_sdram_WEn} <= cmd_d;
            io_sdram_ADDR                             <= addr_d;
            io_sdram_BA                               <= ba_d;
            io_sdram_DQM                              <= dqm_d;
            io_sdram_DQ_write                         <= is_write ? io_cmd_wdata : '0;
            io_sdram_DQ_writeEnable                   <= is_write;
            io_cmd_ready                              <= init_done;
            io_initDone                               <= init_done;
            rd_pipe                                   <= {rd_pipe[CAS_LATENCY:0], is_read};
            // Device data for a READ on the pins at k+1 is valid during
            // k+1+CAS_LATENCY; capture it at the edge that raises rsp_valid.
            if (rd_pipe[CAS_LATENCY])
                io_rsp_data <= io_sdram_DQ_read;
            // A READ accepted 1..CAS_LATENCY+1 cycles ago still owns DQ.
            io_busConflict <= io_busConflict | (is_write & (|rd_pipe[CAS_LATENCY:0]));
        end
    end

    assign io_rsp_valid = rd_pipe[CAS_LATENCY+1];

endmodule

// File: tb/tb_sdram_phy_init.sv
module tb_sdram_phy_init;

    localparam int unsigned CL   = 3;
    localparam int unsigned W    = 16;
    localparam int unsigned TRP  = 3;
    localparam int unsigned TRFC = 7;
    localparam int unsigned TMRD = 2;
    localparam logic [12:0] MODE = 13'h030;
    localparam int DONE_CYC = W + TRP + 2 * TRFC + TMRD;
    localparam int NEVER    = 32'h7fffffff;

    localparam logic [2:0] C_NOP   = 3'b111;
    localparam logic [2:0] C_ACT   = 3'b011;
    localparam logic [2:0] C_READ  = 3'b101;
    localparam logic [2:0] C_WRITE = 3'b100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_rasn, cmd_casn, cmd_wen;
    logic [12:0] cmd_addr;
    logic [1:0]  cmd_ba, cmd_dqm;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, init_done, bus_conflict;
    logic [15:0] rsp_data;
    logic [12:0] s_addr;
    logic [1:0]  s_ba, s_dqm;
    logic [15:0] dq_read, dq_write;
    logic        dq_we, s_cke, s_csn, s_rasn, s_casn, s_wen;

    sdram_phy_init #(
        .CAS_LATENCY      (CL),
        .INIT_WAIT_CYCLES (W),
        .T_RP             (TRP),
        .T_RFC            (TRFC),
        .T_MRD            (TMRD),
        .MODE_REG         (MODE)
    ) dut (
        .io_axiClk               (clk),
        .io_axiResetn            (resetn),
        .io_cmd_valid            (cmd_valid),
        .io_cmd_ready            (cmd_ready),
        .io_cmd_rasn             (cmd_rasn),
        .io_cmd_casn             (cmd_casn),
        .io_cmd_wen              (cmd_wen),
        .io_cmd_addr             (cmd_addr),
        .io_cmd_ba               (cmd_ba),
        .io_cmd_dqm              (cmd_dqm),
        .io_cmd_wdata            (cmd_wdata),
        .io_rsp_valid            (rsp_valid),
        .io_rsp_data             (rsp_data),
        .io_initDone             (init_done),
        .io_busConflict          (bus_conflict),
        .io_sdram_ADDR           (s_addr),
        .io_sdram_BA             (s_ba),
        .io_sdram_DQ_read        (dq_read),
        .io_sdram_DQ_write       (dq_write),
        .io_sdram_DQ_writeEnable (dq_we),
        .io_sdram_DQM            (s_dqm),
        .io_sdram_CKE            (s_cke),
        .io_sdram_CSn            (s_csn),
        .io_sdram_RASn           (s_rasn),
        .io_sdram_CASn           (s_casn),
        .io_sdram_WEn            (s_wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    rsp_t        exp_q[$];          // reference: expected responses
    rsp_t        dev_q[$];          // device model: pending DQ drive
    int          read_cycles[$];    // reference: READ acceptance cycles
    logic [15:0] ref_mem [int];     // reference: bank/column -> data
    logic [15:0] dev_mem [int];     // device model: bank/row/column -> data
    logic [12:0] dev_row [4];
    int          bc_from;
    int          cyc;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Advance one clock; run the device model and the per-cycle response
    // and conflict checks against the reference.
    task automatic step();
        logic        in_rst;
        logic        exp_v;
        logic [2:0]  pc;
        int          key;
        in_rst = !resetn;
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) begin
            exp_q.delete();
            dev_q.delete();
            read_cycles.delete();
            bc_from = NEVER;
        end
        if (dev_q.size() > 0 && dev_q[0].due == cyc) begin
            dq_read = dev_q[0].data;
            void'(dev_q.pop_front());
        end else begin
            dq_read = 16'($urandom);
        end
        pc  = {s_rasn, s_casn, s_wen};
        key = int'({s_ba, dev_row[s_ba], s_addr[8:0]});
        if (!s_csn && s_cke) begin
            if (pc == C_ACT) dev_row[s_ba] = s_addr;
            if (pc == C_WRITE && dq_we) dev_mem[key] = dq_write;
            if (pc == C_READ)
                dev_q.push_back('{due: cyc + int'(CL), data: dev_mem.exists(key) ? dev_mem[key] : 16'h0});
        end
        exp_v = (exp_q.size() > 0 && exp_q[0].due == cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end
        chk("bus_conflict", 32'(bus_conflict), 32'(cyc >= bc_from));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_pins", 32'({s_cke, s_csn, s_rasn, s_casn, s_wen, s_dqm, dq_we}), 32'(8'b1_0111_00_0));
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                         input logic [15:0] wd);
        int k;
        int rkey;
        k    = cyc;
        rkey = int'({ba, addr[8:0]});
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        {cmd_rasn, cmd_casn, cmd_wen} = c;
        cmd_ba    = ba;
        cmd_addr  = addr;
        cmd_dqm   = 2'b00;
        cmd_wdata = wd;
        if (c == C_READ) begin
            exp_q.push_back('{due: k + int'(CL) + 2, data: ref_mem.exists(rkey) ? ref_mem[rkey] : 16'h0});
            read_cycles.push_back(k);
        end
        if (c == C_WRITE) begin
            foreach (read_cycles[i])
                if (k - read_cycles[i] >= 1 && k - read_cycles[i] <= int'(CL) + 1 && bc_from > k + 1)
                    bc_from = k + 1;
            ref_mem[rkey] = wd;
        end
        step();
        cmd_valid = 1'b0;
        chk("cmd_pins", 32'({s_cke, s_csn, s_rasn, s_casn, s_wen}), 32'({2'b10, c}));
        chk("cmd_addr_ba", 32'({s_ba, s_addr}), 32'({ba, addr}));
        chk("cmd_dqm", 32'(s_dqm), 32'd0);
        chk("dq_we", 32'(dq_we), 32'(c == C_WRITE));
        if (c == C_WRITE) chk("dq_write", 32'(dq_write), 32'(wd));
    endtask

    task automatic chk_reset_pins();
        chk("rst_ctrl", 32'({s_cke, s_csn, s_rasn, s_casn, s_wen}), 32'(5'b01111));
        chk("rst_addr_ba_dqm", 32'({s_addr, s_ba, s_dqm}), 32'({13'h0, 2'b00, 2'b11}));
        chk("rst_dq", 32'({dq_we, dq_write}), 32'd0);
        chk("rst_status", 32'({cmd_ready, rsp_valid, init_done, bus_conflict, rsp_data}), 32'd0);
    endtask

    // Release reset and follow the power-up sequence pin by pin; a WRITE is
    // held valid during part of init and must be ignored.
    task automatic init_check();
        logic [3:0] e;
        resetn = 1'b1;
        cyc    = -1;
        for (int p = 0; p <= DONE_CYC + 1; p++) begin
            step();
            e = 4'b0111;
            if (p == W)                                  e = 4'b0010;
            if (p == W + TRP || p == W + TRP + TRFC)     e = 4'b0001;
            if (p == W + TRP + 2 * TRFC)                 e = 4'b0000;
            chk("init_cke", 32'(s_cke), 32'd1);
            chk("init_cmd", 32'({s_csn, s_rasn, s_casn, s_wen}), 32'(e));
            chk("init_dqm", 32'(s_dqm), (p < DONE_CYC) ? 32'd3 : 32'd0);
            chk("init_done", 32'({init_done, cmd_ready}), (p >= DONE_CYC) ? 32'd3 : 32'd0);
            chk("init_dq_we", 32'(dq_we), 32'd0);
            if (e == 4'b0010) chk("pre_a10", 32'(s_addr[10]), 32'd1);
            if (e == 4'b0000) chk("mrs_addr_ba", 32'({s_ba, s_addr}), 32'({2'b00, MODE}));
            cmd_valid = (p >= 3 && p < 25);
            {cmd_rasn, cmd_casn, cmd_wen} = C_WRITE;
            cmd_wdata = 16'hA5A5;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        int r;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        {cmd_rasn, cmd_casn, cmd_wen} = C_NOP;
        cmd_addr  = '0;
        cmd_ba    = '0;
        cmd_dqm   = '0;
        cmd_wdata = '0;
        dq_read   = '0;
        bc_from   = NEVER;
        cyc       = 0;
        foreach (dev_row[i]) dev_row[i] = '0;

        repeat (3) step();
        chk_reset_pins();

        // Power-up sequence
        init_check();

        // WRITE then READ back of the same word
        issue(C_ACT, 2'd1, 13'h0, 16'h0);
        idle(2);
        issue(C_WRITE, 2'd1, 13'h055, 16'hBEEF);
        idle(1);
        issue(C_READ, 2'd1, 13'h055, 16'h0);
        idle(6);

        // Back-to-back reads
        issue(C_ACT, 2'd0, 13'h0, 16'h0);
        idle(2);
        for (int i = 0; i < 4; i++) issue(C_WRITE, 2'd0, 13'(i), 16'h1111 * 16'(i + 1));
        idle(1);
        for (int i = 0; i < 4; i++) issue(C_READ, 2'd0, 13'(i), 16'h0);
        idle(8);

        // WRITE exactly CL+2 after a READ: legal
        issue(C_READ, 2'd0, 13'h0, 16'h0);
        idle(4);
        issue(C_WRITE, 2'd0, 13'h0, 16'h1111);
        idle(6);

        // WRITE 2 cycles after a READ: conflict, sticky
        issue(C_READ, 2'd0, 13'h1, 16'h0);
        idle(1);
        issue(C_WRITE, 2'd0, 13'h1, 16'h2222);
        idle(8);

        // Reset one cycle after a READ is accepted
        issue(C_READ, 2'd0, 13'h2, 16'h0);
        resetn = 1'b0;
        step();
        chk_reset_pins();
        repeat (6) step();
        chk_reset_pins();
        init_check();

        // Randomized traffic against the reference model
        ref_mem.delete();
        for (int b = 0; b < 4; b++) begin
            issue(C_ACT, 2'(b), 13'($urandom_range(0, 8191)), 16'h0);
            idle(1);
        end
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < 8; c++)
                issue(C_WRITE, 2'(b), 13'(c), 16'($urandom));
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 3));
            if (r == 1)      issue(C_READ, 2'($urandom_range(0, 3)), 13'($urandom_range(0, 7)), 16'h0);
            else if (r == 2) issue(C_WRITE, 2'($urandom_range(0, 3)), 13'($urandom_range(0, 7)), 16'($urandom));
            else             idle(1);
        end
        idle(10);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
